pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
Central run/hazard controller for the 5-stage (IF/ID/EX/MEM/WB) processor datapath.
- Sequences program execution from the start pulse through halt drain.
- Tracks per-stage valid bits and stalls the front end on load-use hazards.
- Flushes wrong-path instructions on taken jumps resolved in EX, and selects operand forwarding sources for EX.
- Keeps saturating performance counters.

Parameters:
- REG_AW, 4, register address width (16 registers).
- ZERO_REG, 1, when 1 register 0 never forwards and never causes a stall.
- CNT_W, 16, width of the performance counters.
- DRAIN_CYCLES, 3, cycles spent in DRAIN after halt leaves ID (EX, MEM, WB).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin execution; rising edge sampled in IDLE or DONE.
- id_halt  in  1  decoder flags a halt instruction in ID.
- id_ra1, id_ra2  in  REG_AW  source register addresses in ID.
- id_use1, id_use2  in  1  ID instruction actually reads ra1/ra2.
- ex_wa, mem_wa, wb_wa  in  REG_AW  destination address per stage.
- ex_regwrite, mem_regwrite, wb_regwrite  in  1  RegWrite per stage (unqualified).
- ex_memread  in  1  EX instruction is a load.
- ex_jump_taken  in  1  jump/branch taken in EX (JumpI or satisfied JumpCI/JumpCD).
- pc_clr  out  1  one-cycle pulse that clears the PC to 0.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID register load enable.
- if_id_flush  out  1  IF/ID register becomes a bubble.
- id_ex_flush  out  1  ID/EX register becomes a bubble.
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 10 MEM-stage result, 01 WB-stage result.
- stage_valid  out  4  {wb, mem, ex, id} valid bits.
- running  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.
- cycle_cnt, stall_cnt, flush_cnt  out  CNT_W  performance counters.

Behaviour:
- Reset (async, any time, including mid-run): state=IDLE; all valids=0; counters=0.
  - Outputs: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1, pc_clr=0, fwd_a=fwd_b=00, running=0, done=0.
- Start edge detector uses a registered copy of start; the registered copy resets to 0.
- States:
  - IDLE: front end frozen, flush outputs held at 1. On start rising edge: pc_clr=1 that cycle, counters cleared, go to RUN.
  - RUN: pc_en=if_id_en=1 unless stalling. Valid chain shifts each cycle: id<=1 (IF fetched), ex<=id, mem<=ex, wb<=mem; bubbles insert 0.
  - RUN to DRAIN: when id_halt & v_id & no stall & no ex_jump_taken. In that same cycle and thereafter pc_en=0 and if_id_flush=1; the halt itself proceeds to EX as a bubble.
  - DRAIN: down-counter loaded with DRAIN_CYCLES; front end frozen; ex/mem/wb continue to shift. At count 0, go to DONE.
  - DONE: done=1, everything frozen. Start rising edge behaves as in IDLE (restart).
- Qualified writes: Xq = X_regwrite & v_X, for X in ex, mem, wb.
- Match(a,X) = Xq & (X_wa==a) & !(ZERO_REG & a==0).
- Load-use stall = v_id & v_ex & ex_memread & ((id_use1 & Match(ra1,ex)) | (id_use2 & Match(ra2,ex))).
  - Action: pc_en=0, if_id_en=0, id_ex_flush=1 for exactly one cycle; the next cycle re-evaluates.
- Taken jump: ex_jump_taken & v_ex. Action: if_id_flush=1, id_ex_flush=1, pc_en=1 (PC loads target), v_id<=0, v_ex<=0.
  - Jump beats a simultaneous stall and a simultaneous halt in ID.
- Forwarding is purely combinational on the registered ID/EX-side addresses presented for the EX instruction:
  - fwd=10 if Match(addr,mem); else 01 if Match(addr,wb); else 00. MEM has priority over WB.
  - fwd is forced to 00 when not running.
- Counters, updated only while running:
  - cycle_cnt +1 per cycle.
  - stall_cnt +1 per load-use stall cycle.
  - flush_cnt +1 per taken jump.
  - All saturate at 2^CNT_W-1.

Decomposition:
- Package pipeline_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - fwd_sel_t localparams FWD_RF=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01;
  - REG_AW default.
- One sub-module hazard_fwd_unit: combinational match/stall/forward logic, parametrised by REG_AW and ZERO_REG.
- FSM, valid chain and counters stay in pipeline_ctrl.

Test Plan:
- Reset mid-RUN: assert rst while cycle_cnt=7 -> same cycle state=IDLE, stage_valid=0000, pc_en=0, counters=0.
- Start then 5 idle cycles of independent instructions -> pc_clr high for 1 cycle, then stage_valid fills 0001, 0011, 0111, 1111; cycle_cnt=5.
- Load-use: ex_memread=1, ex_wa=3, id_ra1=3, id_use1=1 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle fwd_a=10; stall_cnt=1.
- Forward priority: mem_wa=wb_wa=5, both regwrite, EX ra=5 -> fwd=10. Same with ra=0, ZERO_REG=1 -> fwd=00.
- Jump with simultaneous load-use and halt in ID: ex_jump_taken=1 -> if_id_flush=id_ex_flush=1, pc_en=1, no stall, no DRAIN, flush_cnt=1.
- Halt: id_halt in RUN -> pc_en=0 from that cycle; DONE asserted 3 cycles after DRAIN entry. A start edge in DONE -> pc_clr pulse and counters cleared.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage pipeline run/hazard controller.
package pipeline_pkg;

   localparam int PIPE_REG_AW = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef logic [1:0] fwd_sel_t;

   localparam fwd_sel_t FWD_RF  = 2'b00;
   localparam fwd_sel_t FWD_MEM = 2'b10;
   localparam fwd_sel_t FWD_WB  = 2'b01;

endpackage

// File: rtl/pipeline_ctrl_hazard.sv
// Combinational register-match logic: load-use stall detection and EX operand
// forwarding selection. Register 0 can be excluded from both.
module hazard_fwd_unit
   import pipeline_pkg::*;
#(
   parameter int REG_AW   = PIPE_REG_AW,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              v_id,
   input  logic              v_ex,
   input  logic [REG_AW-1:0] id_ra1,
   input  logic [REG_AW-1:0] id_ra2,
   input  logic              id_use1,
   input  logic              id_use2,
   input  logic [REG_AW-1:0] ex_ra1,
   input  logic [REG_AW-1:0] ex_ra2,
   input  logic [REG_AW-1:0] ex_wa,
   input  logic [REG_AW-1:0] mem_wa,
   input  logic [REG_AW-1:0] wb_wa,
   input  logic              ex_q,
   input  logic              mem_q,
   input  logic              wb_q,
   input  logic              ex_memread,
   output logic              stall,
   output fwd_sel_t          fwd_a,
   output fwd_sel_t          fwd_b
);

   function automatic logic match(input logic q, input logic [REG_AW-1:0] wa,
                                  input logic [REG_AW-1:0] a);
      return q && (wa == a) && !(ZERO_REG && (a == '0));
   endfunction

   function automatic fwd_sel_t pick(input logic [REG_AW-1:0] a);
      if (match(mem_q, mem_wa, a))
         return FWD_MEM;
      else if (match(wb_q, wb_wa, a))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

   always_comb begin
      stall = v_id && v_ex && ex_memread &&
              ((id_use1 && match(ex_q, ex_wa, id_ra1)) ||
               (id_use2 && match(ex_q, ex_wa, id_ra2)));
      fwd_a = pick(ex_ra1);
      fwd_b = pick(ex_ra2);
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Run/hazard controller for the 5-stage datapath: start/halt sequencing,
// per-stage valid chain, stall/flush control, forwarding select, perf counters.
//
//   state | meaning
//   IDLE  | front end frozen, waiting for a start rising edge
//   RUN   | fetching and executing; stalls/flushes applied here
//   DRAIN | halt left ID; EX/MEM/WB empty out, front end frozen
//   DONE  | program finished, all frozen; start edge restarts
module pipeline_ctrl
   import pipeline_pkg::*;
#(
   parameter int REG_AW       = PIPE_REG_AW,
   parameter bit ZERO_REG     = 1'b1,
   parameter int CNT_W        = 16,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              id_halt,
   input  logic [REG_AW-1:0] id_ra1,
   input  logic [REG_AW-1:0] id_ra2,
   input  logic              id_use1,
   input  logic              id_use2,
   input  logic [REG_AW-1:0] ex_wa,
   input  logic [REG_AW-1:0] mem_wa,
   input  logic [REG_AW-1:0] wb_wa,
   input  logic              ex_regwrite,
   input  logic              mem_regwrite,
   input  logic              wb_regwrite,
   input  logic              ex_memread,
   input  logic              ex_jump_taken,
   output logic              pc_clr,
   output logic              pc_en,
   output logic              if_id_en,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [3:0]        stage_valid,
   output logic              running,
   output logic              done,
   output logic [CNT_W-1:0]  cycle_cnt,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   state_t              state, state_nxt;
   logic                start_q;
   logic [3:0]          valid;
   logic [DW-1:0]       drain_cnt;
   logic [REG_AW-1:0]   ex_ra1, ex_ra2;
   logic                stall_raw;
   fwd_sel_t            fwd_a_raw, fwd_b_raw;
   logic                start_rise, in_run, jump, stall_eff, halt_go;

   hazard_fwd_unit #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_hazard (
      .v_id       (valid[0]),
      .v_ex       (valid[1]),
      .id_ra1     (id_ra1),
      .id_ra2     (id_ra2),
      .id_use1    (id_use1),
      .id_use2    (id_use2),
      .ex_ra1     (ex_ra1),
      .ex_ra2     (ex_ra2),
      .ex_wa      (ex_wa),
      .mem_wa     (mem_wa),
      .wb_wa      (wb_wa),
      .ex_q       (ex_regwrite & valid[1]),
      .mem_q      (mem_regwrite & valid[2]),
      .wb_q       (wb_regwrite & valid[3]),
      .ex_memread (ex_memread),
      .stall      (stall_raw),
      .fwd_a      (fwd_a_raw),
      .fwd_b      (fwd_b_raw)
   );

   // A taken jump in EX overrides both a load-use stall and a halt in ID.
   assign start_rise = start & ~start_q;
   assign in_run     = (state == RUN);
   assign jump       = in_run & ex_jump_taken & valid[1];
   assign stall_eff  = in_run & stall_raw & ~jump;
   assign halt_go    = in_run & id_halt & valid[0] & ~stall_raw & ~jump;

   assign running     = (state == RUN) || (state == DRAIN);
   assign done        = (state == DONE);
   assign stage_valid = valid;
   assign fwd_a       = running ? fwd_a_raw : FWD_RF;
   assign fwd_b       = running ? fwd_b_raw : FWD_RF;

   always_comb begin
      state_nxt   = state;
      pc_clr      = 1'b0;
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      case (state)
         IDLE, DONE: begin
            if (start_rise) begin
               pc_clr    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (jump) begin
               pc_en    = 1'b1;
               if_id_en = 1'b1;
            end else if (stall_eff) begin
               if_id_flush = 1'b0;
            end else if (halt_go) begin
               state_nxt = DRAIN;
            end else begin
               pc_en       = 1'b1;
               if_id_en    = 1'b1;
               if_id_flush = 1'b0;
               id_ex_flush = 1'b0;
            end
         end
         DRAIN: begin
            if (drain_cnt == '0)
               state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         start_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         start_q <= start;
      end
   end

   // Valid chain is {wb, mem, ex, id}; bubbles shift in as 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid     <= '0;
         drain_cnt <= '0;
         ex_ra1    <= '0;
         ex_ra2    <= '0;
      end else begin
         ex_ra1 <= id_ra1;
         ex_ra2 <= id_ra2;
         case (state)
            RUN: begin
               if (jump || halt_go)
                  valid <= {valid[2:1], 2'b00};
               else if (stall_eff)
                  valid <= {valid[2:1], 1'b0, valid[0]};
               else
                  valid <= {valid[2:0], 1'b1};
               if (halt_go)
                  drain_cnt <= DW'(DRAIN_CYCLES - 1);
            end
            DRAIN: begin
               valid <= {valid[2:0], 1'b0};
               if (drain_cnt != '0)
                  drain_cnt <= drain_cnt - 1'b1;
            end
            default: begin
               if (start_rise)
                  valid <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (start_rise && (state == IDLE || state == DONE)) begin
         cycle_cnt <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (running) begin
         cycle_cnt <= cycle_cnt + {{(CNT_W-1){1'b0}}, ~&cycle_cnt};
         if (stall_eff)
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, ~&stall_cnt};
         if (jump)
            flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, ~&flush_cnt};
      end
   end

endmodule
